div_result_collector: RTL

- Sits directly downstream of the pipelined non-restoring divider.
- Gates request issue with a credit check and tracks each in-flight operation's mode, divisor and tag in a latency-matched side pipeline.
- Captures the divider's raw result at the right cycle, applies the final non-restoring remainder correction and divide-by-zero override, then queues results in a small FIFO.
- Presents results to the consumer on a valid/ready interface with full backpressure.

---
 rtl/div_result_collector.sv | 131 +++++++++++++
 1 files changed

// File: rtl/div_result_collector.sv
// Result collector behind the pipelined non-restoring divider. It issues requests
// against a credit pool, applies the final remainder fix-up and divide-by-zero
// override, and queues results in a FWFT FIFO.
module div_result_collector #(
  parameter int LATENCY    = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [15:0]      in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_fire,
  input  logic [31:0]      div_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_mode,
  output logic             out_dz
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + LATENCY + 1);
  localparam int L     = LATENCY - 1;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             mode;
    logic             dz;
  } res_t;

  // Side pipeline: stage L lines up with div_result
  logic [LATENCY-1:0]            vld_pipe_q;
  logic [LATENCY-1:0]            mode_pipe_q;
  logic [LATENCY-1:0][15:0]      dvs_pipe_q;
  logic [LATENCY-1:0][TAG_W-1:0] tag_pipe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_pipe_q <= '0;
    else       vld_pipe_q <= {vld_pipe_q[LATENCY-2:0], div_fire};
  end

  always_ff @(posedge clk) begin
    mode_pipe_q <= {mode_pipe_q[LATENCY-2:0], in_mode};
    dvs_pipe_q  <= {dvs_pipe_q[LATENCY-2:0], in_divisor};
    tag_pipe_q  <= {tag_pipe_q[LATENCY-2:0], in_tag};
  end

  // Credit check uses registered state only
  logic [CNT_W-1:0] inflight;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++)
      inflight = inflight + {{(CNT_W-1){1'b0}}, vld_pipe_q[i]};
  end

  assign in_ready = ({{(CNT_W-PTR_W-1){1'b0}}, count_q} + inflight) < CNT_W'(FIFO_DEPTH);
  assign div_fire = in_valid && in_ready;

  // Final correction of the raw divider result
  res_t        push_ent;
  logic [15:0] rem_fix;

  assign rem_fix = div_result[15:0] + dvs_pipe_q[L];

  always_comb begin
    push_ent      = '0;
    push_ent.tag  = tag_pipe_q[L];
    push_ent.mode = mode_pipe_q[L];
    if (dvs_pipe_q[L] == 16'd0) begin
      push_ent.data = 32'hFFFF_FFFF;
      push_ent.dz   = 1'b1;
    end else if (mode_pipe_q[L]) begin
      push_ent.data = {15'b0, div_result[16:0]};
    end else if (div_result[15]) begin
      push_ent.data = {16'b0, rem_fix};
    end else begin
      push_ent.data = {16'b0, div_result[15:0]};
    end
  end

  // FWFT result FIFO
  res_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             push, pop;

  assign push = vld_pipe_q[L];
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= push_ent;
    end
  end

  res_t head;
  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_data  = head.data;
  assign out_tag   = head.tag;
  assign out_mode  = head.mode;
  assign out_dz    = head.dz;

endmodule
